// File: rtl/i2c_csr_bank.sv
// Clocked CSR bank for the I2C master: config, sticky W1C status, self-clearing START,
// saturating byte counters, registered read port and registered interrupt.
module i2c_csr_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 32,
    parameter int DIV_W  = 16,
    parameter int STB_W  = DATA_W/8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_en_i,
    input  logic [STB_W-1:0]  wr_strb_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              busy_i,
    input  logic              start_ack_i,
    input  logic [5:0]        evt_i,
    input  logic              bus_available_i,
    input  logic              arb_loss_i,
    input  logic              rx_byte_i,
    input  logic [7:0]        rx_data_i,
    input  logic              tx_byte_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_load_o,
    output logic [LEN_W-1:0]  read_len_o,
    output logic [LEN_W-1:0]  write_len_o,
    output logic [DIV_W-1:0]  clk_div_o,
    output logic              fifo_en_o,
    output logic              packet_type_o,
    output logic              start_o,
    output logic              master_ack_o,
    output logic              master_nack_o,
    output logic              sr_en_o,
    output logic              irq_o
);

    localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_RLEN = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_WLEN = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_BRD  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_BWR  = ADDR_W'(8);
    localparam int CFG_START = 2;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [7:0]       tx_data_q;
    logic [7:0]       rx_data_q;
    logic [LEN_W-1:0] read_len_q;
    logic [LEN_W-1:0] write_len_q;
    logic [DIV_W-1:0] clk_div_q;
    logic [7:0]       irq_en_q;
    // cfg_q holds config bits 13:8: sr_en, master_nack, master_ack, start, packet_type, fifo_en
    logic [5:0]       cfg_q;
    logic [5:0]       cfg_nxt;
    logic [5:0]       status_q;
    logic             bus_avail_q;
    logic             arb_loss_q;
    logic [LEN_W-1:0] bytes_rd_q;
    logic [LEN_W-1:0] bytes_wr_q;
    logic             irq_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_mux;
    logic             rd_valid_q;
    logic             tx_load_q;

    logic [DATA_W-1:0] wmask;
    logic [LEN_W-1:0]  rlen_nxt;
    logic [LEN_W-1:0]  wlen_nxt;
    logic [DIV_W-1:0]  div_nxt;
    logic [5:0]        stat_clr;
    logic wr_tx, wr_rlen, wr_wlen, wr_div, wr_cfg, wr_stat;

    genvar g;
    generate
        for (g = 0; g < DATA_W; g++) begin : g_mask
            assign wmask[g] = wr_strb_i[g/8];
        end
    endgenerate

    // Length/divider registers are locked while the core is busy.
    assign wr_tx   = wr_en_i && (addr_i == A_TX);
    assign wr_rlen = wr_en_i && (addr_i == A_RLEN) && !busy_i;
    assign wr_wlen = wr_en_i && (addr_i == A_WLEN) && !busy_i;
    assign wr_div  = wr_en_i && (addr_i == A_DIV)  && !busy_i;
    assign wr_cfg  = wr_en_i && (addr_i == A_CFG);
    assign wr_stat = wr_en_i && (addr_i == A_STAT) && wr_strb_i[0];

    assign rlen_nxt = (read_len_q  & ~wmask[LEN_W-1:0]) | (wr_data_i[LEN_W-1:0] & wmask[LEN_W-1:0]);
    assign wlen_nxt = (write_len_q & ~wmask[LEN_W-1:0]) | (wr_data_i[LEN_W-1:0] & wmask[LEN_W-1:0]);
    assign div_nxt  = (clk_div_q   & ~wmask[DIV_W-1:0]) | (wr_data_i[DIV_W-1:0] & wmask[DIV_W-1:0]);
    assign stat_clr = wr_stat ? wr_data_i[5:0] : 6'd0;

    // START ack overrides a same-cycle software set.
    always_comb begin
        cfg_nxt = cfg_q;
        if (wr_cfg && wr_strb_i[1] && !busy_i)
            cfg_nxt = wr_data_i[13:8];
        if (start_ack_i)
            cfg_nxt[CFG_START] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data_q   <= '0;
            read_len_q  <= '0;
            write_len_q <= '0;
            clk_div_q   <= DIV_W'(1);
            irq_en_q    <= '0;
            cfg_q       <= '0;
            tx_load_q   <= 1'b0;
        end else begin
            if (wr_tx && wr_strb_i[0])
                tx_data_q <= wr_data_i[7:0];
            if (wr_rlen)
                read_len_q <= rlen_nxt;
            if (wr_wlen)
                write_len_q <= wlen_nxt;
            if (wr_div)
                clk_div_q <= div_nxt;
            if (wr_cfg && wr_strb_i[0])
                irq_en_q <= wr_data_i[7:0];
            cfg_q     <= cfg_nxt;
            tx_load_q <= wr_tx && wr_strb_i[0];
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q    <= '0;
            bus_avail_q <= 1'b0;
            arb_loss_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            status_q    <= (status_q & ~stat_clr) | evt_i;
            bus_avail_q <= bus_available_i;
            arb_loss_q  <= arb_loss_i;
            irq_q       <= |({arb_loss_q, bus_avail_q, status_q} & irq_en_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q  <= '0;
            bytes_rd_q <= '0;
            bytes_wr_q <= '0;
        end else begin
            if (rx_byte_i)
                rx_data_q <= rx_data_i;
            if (start_ack_i)
                bytes_rd_q <= '0;
            else if (rx_byte_i && bytes_rd_q != LEN_MAX)
                bytes_rd_q <= bytes_rd_q + LEN_W'(1);
            if (start_ack_i)
                bytes_wr_q <= '0;
            else if (tx_byte_i && bytes_wr_q != LEN_MAX)
                bytes_wr_q <= bytes_wr_q + LEN_W'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            A_TX:    rd_mux = DATA_W'(tx_data_q);
            A_RX:    rd_mux = DATA_W'(rx_data_q);
            A_RLEN:  rd_mux = DATA_W'(read_len_q);
            A_WLEN:  rd_mux = DATA_W'(write_len_q);
            A_DIV:   rd_mux = DATA_W'(clk_div_q);
            A_CFG:   rd_mux = DATA_W'({cfg_q, irq_en_q});
            A_STAT:  rd_mux = DATA_W'({arb_loss_q, bus_avail_q, status_q});
            A_BRD:   rd_mux = DATA_W'(bytes_rd_q);
            A_BWR:   rd_mux = DATA_W'(bytes_wr_q);
            default: rd_mux = '0;
        endcase
    end

    // Read samples pre-write state, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_en_i ? rd_mux : '0;
            rd_valid_q <= rd_en_i;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign tx_data_o     = tx_data_q;
    assign tx_load_o     = tx_load_q;
    assign read_len_o    = read_len_q;
    assign write_len_o   = write_len_q;
    assign clk_div_o     = clk_div_q;
    assign fifo_en_o     = cfg_q[0];
    assign packet_type_o = cfg_q[1];
    assign start_o       = cfg_q[CFG_START];
    assign master_ack_o  = cfg_q[3];
    assign master_nack_o = cfg_q[4];
    assign sr_en_o       = cfg_q[5];
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_i2c_csr_bank.sv
// Directed + randomized bench for i2c_csr_bank against a register-map level reference model.
module tb_i2c_csr_bank;
    localparam int DW = 32, AW = 4, LW = 4, VW = 16, SW = 4;
    localparam int LMAX = (1 << LW) - 1;

    logic clk = 1'b0, reset;
    logic [AW-1:0] addr_i;
    logic wr_en_i, rd_en_i, rd_valid_o, busy_i, start_ack_i;
    logic [SW-1:0] wr_strb_i;
    logic [DW-1:0] wr_data_i, rd_data_o;
    logic [5:0] evt_i;
    logic bus_available_i, arb_loss_i, rx_byte_i, tx_byte_i, tx_load_o;
    logic [7:0] rx_data_i, tx_data_o;
    logic [LW-1:0] read_len_o, write_len_o;
    logic [VW-1:0] clk_div_o;
    logic fifo_en_o, packet_type_o, start_o, master_ack_o, master_nack_o, sr_en_o, irq_o;

    always #5 clk = ~clk;

    i2c_csr_bank #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .DIV_W(VW), .STB_W(SW)) dut (
        .clk(clk), .reset(reset), .addr_i(addr_i), .wr_en_i(wr_en_i), .wr_strb_i(wr_strb_i),
        .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .busy_i(busy_i), .start_ack_i(start_ack_i), .evt_i(evt_i),
        .bus_available_i(bus_available_i), .arb_loss_i(arb_loss_i), .rx_byte_i(rx_byte_i),
        .rx_data_i(rx_data_i), .tx_byte_i(tx_byte_i), .tx_data_o(tx_data_o), .tx_load_o(tx_load_o),
        .read_len_o(read_len_o), .write_len_o(write_len_o), .clk_div_o(clk_div_o),
        .fifo_en_o(fifo_en_o), .packet_type_o(packet_type_o), .start_o(start_o),
        .master_ack_o(master_ack_o), .master_nack_o(master_nack_o), .sr_en_o(sr_en_o), .irq_o(irq_o)
    );

    int vectors = 0, miscompares = 0;

    // Reference model state, one variable per architectural register
    int m_tx, m_rx, m_rlen, m_wlen, m_div, m_en, m_cfg, m_stat, m_bus, m_arb, m_brd, m_bwr;
    logic [DW-1:0] e_rd;
    logic e_vld, e_txl, e_irq;
    logic [DW-1:0] d;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int merge(input int old, input logic [DW-1:0] wd, input logic [SW-1:0] s, input int bits);
        logic [DW-1:0] r;
        r = DW'(old);
        for (int b = 0; b < SW; b++)
            if (s[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return int'(r) & ((bits >= 32) ? -1 : ((1 << bits) - 1));
    endfunction

    function automatic logic [DW-1:0] m_read(input int a);
        case (a)
            0: return DW'(m_tx);
            1: return DW'(m_rx);
            2: return DW'(m_rlen);
            3: return DW'(m_wlen);
            4: return DW'(m_div);
            5: return DW'(m_cfg * 256 + m_en);
            6: return DW'(m_stat + 64 * m_bus + 128 * m_arb);
            7: return DW'(m_brd);
            8: return DW'(m_bwr);
            default: return '0;
        endcase
    endfunction

    task automatic model_step();
        int clr;
        int a;
        clr = 0;
        a = int'(addr_i);
        if (reset) begin
            m_tx = 0; m_rx = 0; m_rlen = 0; m_wlen = 0; m_div = 1; m_en = 0; m_cfg = 0;
            m_stat = 0; m_bus = 0; m_arb = 0; m_brd = 0; m_bwr = 0;
            e_rd = '0; e_vld = 0; e_txl = 0; e_irq = 0;
            return;
        end
        e_vld = rd_en_i;
        e_rd  = rd_en_i ? m_read(a) : '0;
        e_txl = wr_en_i && a == 0 && wr_strb_i[0];
        e_irq = ((m_stat + 64 * m_bus + 128 * m_arb) & m_en) != 0;
        if (wr_en_i) begin
            if (a == 0 && wr_strb_i[0]) m_tx = int'(wr_data_i[7:0]);
            if (a == 2 && !busy_i) m_rlen = merge(m_rlen, wr_data_i, wr_strb_i, LW);
            if (a == 3 && !busy_i) m_wlen = merge(m_wlen, wr_data_i, wr_strb_i, LW);
            if (a == 4 && !busy_i) m_div = merge(m_div, wr_data_i, wr_strb_i, VW);
            if (a == 5 && wr_strb_i[0]) m_en = int'(wr_data_i[7:0]);
            if (a == 5 && wr_strb_i[1] && !busy_i) m_cfg = int'(wr_data_i[13:8]);
            if (a == 6 && wr_strb_i[0]) clr = int'(wr_data_i[5:0]);
        end
        if (start_ack_i) m_cfg = m_cfg & ~4;
        m_stat = (m_stat & ~clr) | int'(evt_i);
        m_bus = int'(bus_available_i);
        m_arb = int'(arb_loss_i);
        if (rx_byte_i) m_rx = int'(rx_data_i);
        if (start_ack_i) begin
            m_brd = 0; m_bwr = 0;
        end else begin
            if (rx_byte_i && m_brd < LMAX) m_brd = m_brd + 1;
            if (tx_byte_i && m_bwr < LMAX) m_bwr = m_bwr + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rd_valid", DW'(rd_valid_o), DW'(e_vld));
        chk("rd_data", rd_data_o, e_rd);
        chk("tx_load", DW'(tx_load_o), DW'(e_txl));
        chk("irq", DW'(irq_o), DW'(e_irq));
        chk("cfg_out", DW'({sr_en_o, master_nack_o, master_ack_o, start_o, packet_type_o, fifo_en_o}), DW'(m_cfg));
        chk("read_len", DW'(read_len_o), DW'(m_rlen));
        chk("write_len", DW'(write_len_o), DW'(m_wlen));
        chk("clk_div", DW'(clk_div_o), DW'(m_div));
        chk("tx_data", DW'(tx_data_o), DW'(m_tx));
        wr_en_i = 0; rd_en_i = 0; evt_i = '0; rx_byte_i = 0; tx_byte_i = 0; start_ack_i = 0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] wd, input logic [SW-1:0] s);
        addr_i = AW'(a); wr_en_i = 1; wr_data_i = wd; wr_strb_i = s;
        tick();
    endtask

    task automatic rd(input int a, output logic [DW-1:0] q);
        addr_i = AW'(a); rd_en_i = 1;
        tick();
        q = rd_data_o;
    endtask

    initial begin
        reset = 1; addr_i = '0; wr_en_i = 0; rd_en_i = 0; wr_strb_i = '0; wr_data_i = '0;
        busy_i = 0; start_ack_i = 0; evt_i = '0; bus_available_i = 0; arb_loss_i = 0;
        rx_byte_i = 0; rx_data_i = '0; tx_byte_i = 0;
        tick(); tick();
        reset = 0;

        // Reset map: only the divider is non-zero
        for (int a = 0; a < 16; a++) begin
            rd(a, d);
            chk("rst_read", d, (a == 4) ? 32'd1 : 32'd0);
            chk("rst_valid", DW'(rd_valid_o), 32'd1);
        end

        // Event -> status -> irq, then W1C
        wr(5, 32'h0000_0401, 4'hF);
        evt_i = 6'b000001; tick();
        tick();
        chk("irq_set", DW'(irq_o), 32'd1);
        rd(6, d);
        chk("status_set", d, 32'h01);
        wr(6, 32'h1, 4'hF);
        tick();
        chk("irq_clr", DW'(irq_o), 32'd0);

        // Set beats clear in the same cycle
        evt_i = 6'b000001;
        wr(6, 32'h1, 4'hF);
        rd(6, d);
        chk("set_wins", d, 32'h01);

        // START: ack beats software rewrite
        wr(5, 32'h0000_0401, 4'hF);
        chk("start_set", DW'(start_o), 32'd1);
        start_ack_i = 1;
        wr(5, 32'h0000_0401, 4'hF);
        chk("start_ack", DW'(start_o), 32'd0);

        // Busy locks lengths and config bits, not enables
        wr(5, 32'h0000_3B01, 4'hF);
        wr(2, 32'h0A, 4'hF);
        busy_i = 1;
        wr(2, 32'h55, 4'hF);
        wr(5, 32'hFF, 4'hF);
        rd(2, d);
        chk("busy_rlen", d, 32'h0A);
        rd(5, d);
        chk("busy_cfg", d, 32'h3BFF);
        busy_i = 0;

        // Saturating counters and ack clear
        for (int i = 0; i < 20; i++) begin
            rx_byte_i = 1; rx_data_i = 8'($urandom); tick();
        end
        rd(7, d);
        chk("brd_sat", d, 32'd15);
        start_ack_i = 1; rx_byte_i = 1; tick();
        rd(7, d);
        chk("brd_clr", d, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tx_byte_i = 1; tick();
        end
        rd(8, d);
        chk("bwr_cnt", d, 32'd3);

        // Byte strobes on the divider
        reset = 1; tick(); reset = 0;
        wr(4, 32'h1234, 4'b0010);
        rd(4, d);
        chk("div_strb", d, 32'h1201);

        // tx_load pulse only with lane 0
        wr(0, 32'hA5, 4'b0001);
        chk("tx_load_hi", DW'(tx_load_o), 32'd1);
        tick();
        chk("tx_load_lo", DW'(tx_load_o), 32'd0);
        wr(0, 32'h5A, 4'b0010);
        chk("tx_load_nostrb", DW'(tx_load_o), 32'd0);
        chk("tx_data_hold", DW'(tx_data_o), 32'hA5);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            addr_i = AW'($urandom_range(0, 15));
            wr_en_i = ($urandom_range(0, 2) == 0);
            rd_en_i = 1'($urandom);
            wr_strb_i = SW'($urandom);
            wr_data_i = $urandom;
            busy_i = ($urandom_range(0, 3) == 0);
            evt_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            rx_byte_i = 1'($urandom); rx_data_i = 8'($urandom);
            tx_byte_i = 1'($urandom);
            start_ack_i = ($urandom_range(0, 31) == 0);
            bus_available_i = 1'($urandom); arb_loss_i = 1'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 0;
        busy_i = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
